instr_encoder: RTL and testbench

- Inverse of the immediate/sign-extend decode path: accepts instruction fields and packs them into 16-bit instruction words.
- Writes the packed words sequentially into instruction memory through its write port.
- Used by the test loader and self-modifying-program bring-up.
- Bit layouts match the decode side exactly, so an encode-then-decode round trip returns the original immediate.

---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 177 +++++++++++++++++
 tb/tb_instr_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Loader-side bundle channel and instruction-memory write channel of instr_encoder.
// slave = the encoder; master = the loader/memory environment driving it.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [3:0]        funct;
  logic [9:0]        imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_busy;
  logic              done;
  logic              err_imm;
  logic              err_op;
  logic [7:0]        err_count;

  modport slave (
    input  start, base_addr, in_valid, opcode, rd, rs1, rs2, funct, imm, mem_busy,
    output in_ready, mem_we, mem_addr, mem_wdata, done, err_imm, err_op, err_count
  );

  modport master (
    output start, base_addr, in_valid, opcode, rd, rs1, rs2, funct, imm, mem_busy,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, err_imm, err_op, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 16-bit words and writes them sequentially to
// instruction memory. Optional macro IMM_SAT_EN saturates out-of-range short immediates.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LAST_ADDR = 255
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] OP_R  = 3'b000;
  localparam logic [2:0] OP_I  = 3'b001;
  localparam logic [2:0] OP_LW = 3'b010;
  localparam logic [2:0] OP_SW = 3'b011;
  localparam logic [2:0] OP_SB = 3'b100;
  localparam logic [2:0] OP_UJ = 3'b101;

  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [1:0] state;
  logic [1:0] state_next;

  logic              in_ready_next;
  logic              mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [WORD_W-1:0] mem_wdata_next;
  logic              done_next;
  logic              err_imm_next;
  logic              err_op_next;
  logic [CNT_W-1:0]  err_count_next;

  logic              short_imm_c;
  logic              op_reserved_c;
  logic              imm_in_range_c;
  logic              imm_bad_c;
  logic              imm_reject_c;
  logic [3:0]        imm4_c;
  logic [WORD_W-1:0] packed_c;

  // Bundle classification: short-immediate formats must fit in a signed 4-bit field.
  assign short_imm_c    = (bus.opcode == OP_I)  || (bus.opcode == OP_LW) ||
                          (bus.opcode == OP_SW) || (bus.opcode == OP_SB);
  assign op_reserved_c  = bus.opcode[2] & bus.opcode[1];
  assign imm_in_range_c = (bus.imm[9:4] == {6{bus.imm[3]}});
  assign imm_bad_c      = short_imm_c & ~imm_in_range_c;

`ifdef IMM_SAT_EN
  assign imm_reject_c = 1'b0;
  assign imm4_c       = !imm_bad_c ? bus.imm[3:0] : (bus.imm[9] ? 4'b1000 : 4'b0111);
`else
  assign imm_reject_c = imm_bad_c;
  assign imm4_c       = bus.imm[3:0];
`endif

  // Field packing; layouts mirror the decoder so immediates round-trip.
  always_comb begin
    packed_c = '0;
    case (bus.opcode)
      OP_R:         packed_c = {bus.funct, bus.rs2, bus.rs1, bus.rd, bus.opcode};
      OP_I, OP_LW:  packed_c = {imm4_c, bus.funct[2:0], bus.rs1, bus.rd, bus.opcode};
      OP_SW, OP_SB: packed_c = {imm4_c[3], bus.funct[2:0], bus.rs2, bus.rs1,
                                imm4_c[2:0], bus.opcode};
      OP_UJ:        packed_c = {bus.imm, bus.rd, bus.opcode};
      default:      packed_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_next     = state;
    in_ready_next  = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = bus.mem_addr;
    mem_wdata_next = bus.mem_wdata;
    done_next      = 1'b0;
    err_imm_next   = 1'b0;
    err_op_next    = 1'b0;
    err_count_next = bus.err_count;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_ACCEPT;
          mem_addr_next = bus.base_addr;
          in_ready_next = 1'b1;
        end
      end

      ST_ACCEPT: begin
        in_ready_next = 1'b1;
        if (bus.in_valid && bus.in_ready) begin
          if (op_reserved_c || imm_reject_c) begin
            err_op_next  = op_reserved_c;
            err_imm_next = ~op_reserved_c;
            if (bus.err_count != CNT_MAX) begin
              err_count_next = bus.err_count + CNT_W'(1);
            end
          end else begin
            state_next     = ST_WRITE;
            mem_wdata_next = packed_c;
            mem_we_next    = 1'b1;
            in_ready_next  = 1'b0;
            err_imm_next   = imm_bad_c;
          end
        end
      end

      ST_WRITE: begin
        mem_we_next = 1'b1;
        if (!bus.mem_busy) begin
          mem_we_next = 1'b0;
          if (bus.mem_addr == LAST_A) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next    = ST_ACCEPT;
            mem_addr_next = bus.mem_addr + ADDR_W'(1);
            in_ready_next = 1'b1;
          end
        end
      end

      ST_DONE: begin
        done_next = 1'b1;
        if (bus.start) begin
          state_next    = ST_ACCEPT;
          mem_addr_next = bus.base_addr;
          in_ready_next = 1'b1;
          done_next     = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.done      <= 1'b0;
      bus.err_imm   <= 1'b0;
      bus.err_op    <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.in_ready  <= in_ready_next;
      bus.mem_we    <= mem_we_next;
      bus.mem_addr  <= mem_addr_next;
      bus.mem_wdata <= mem_wdata_next;
      bus.done      <= done_next;
      bus.err_imm   <= err_imm_next;
      bus.err_op    <= err_op_next;
      bus.err_count <= err_count_next;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing, errors, stall, end of session, reset mid-write.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;

  instr_encoder_if #(.ADDR_W(8)) bus ();

  instr_encoder #(.ADDR_W(8), .LAST_ADDR(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  exp_addr;
  logic [7:0]  exp_cnt;
  logic [15:0] cap0;
  logic [15:0] cap1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] decode_imm(input logic [15:0] w);
    case (w[2:0])
      3'b001, 3'b010: decode_imm = {{6{w[15]}}, w[15:12]};
      3'b011, 3'b100: decode_imm = {{6{w[15]}}, w[15], w[5:3]};
      3'b101:         decode_imm = w[15:6];
      default:        decode_imm = '0;
    endcase
  endfunction

  task automatic set_fields(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic [3:0] funct, input logic [9:0] imm);
    bus.opcode = op;
    bus.rd     = rd;
    bus.rs1    = rs1;
    bus.rs2    = rs2;
    bus.funct  = funct;
    bus.imm    = imm;
  endtask

  task automatic do_start(input logic [7:0] base);
    bus.start     = 1'b1;
    bus.base_addr = base;
    tick();
    bus.start = 1'b0;
  endtask

  // Present one bundle for a single cycle; waits (bounded) for in_ready first.
  task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [3:0] funct, input logic [9:0] imm);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    set_fields(op, rd, rs1, rs2, funct, imm);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  32'(bus.in_ready),  32'd0);
    check({tag, "_we"},   32'(bus.mem_we),    32'd0);
    check({tag, "_done"}, 32'(bus.done),      32'd0);
    check({tag, "_eimm"}, 32'(bus.err_imm),   32'd0);
    check({tag, "_eop"},  32'(bus.err_op),    32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr),  32'd0);
    check({tag, "_wd"},   32'(bus.mem_wdata), 32'd0);
    check({tag, "_cnt"},  32'(bus.err_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.mem_busy  = 1'b0;
    set_fields(3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 10'd0);
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_rdy", 32'(bus.in_ready), 32'd0);

    // I-type at base 0x10
    do_start(8'h10);
    check("start_rdy", 32'(bus.in_ready), 32'd1);
    check("start_addr", 32'(bus.mem_addr), 32'h10);
    send(3'b001, 3'd3, 3'd5, 3'd0, 4'd2, 10'h3FD);
    check("i_we", 32'(bus.mem_we), 32'd1);
    check("i_addr", 32'(bus.mem_addr), 32'h10);
    check("i_wd", 32'(bus.mem_wdata), 32'hD559);
    check("i_rdy", 32'(bus.in_ready), 32'd0);
    check("i_dec", 32'(decode_imm(bus.mem_wdata)), 32'h3FD);
    tick();
    check("i_we_off", 32'(bus.mem_we), 32'd0);
    check("i_rdy_back", 32'(bus.in_ready), 32'd1);
    check("i_next_addr", 32'(bus.mem_addr), 32'h11);

    // SW then UJ back to back
    send(3'b011, 3'd0, 3'd1, 3'd2, 4'd0, 10'h005);
    check("sw_addr", 32'(bus.mem_addr), 32'h11);
    check("sw_wd", 32'(bus.mem_wdata), 32'h046B);
    cap0 = bus.mem_wdata;
    set_fields(3'b101, 3'd7, 3'd0, 3'd0, 4'd0, 10'h2A5);
    bus.in_valid = 1'b1;
    tick();
    check("uj_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("uj_we", 32'(bus.mem_we), 32'd1);
    check("uj_addr", 32'(bus.mem_addr), 32'h12);
    check("uj_wd", 32'(bus.mem_wdata), 32'hA97D);
    cap1 = bus.mem_wdata;
    check("sw_dec", 32'(decode_imm(cap0)), 32'h005);
    check("uj_dec", 32'(decode_imm(cap1)), 32'h2A5);
    tick();
    exp_addr = 8'h13;
    check("uj_next_addr", 32'(bus.mem_addr), 32'(exp_addr));

    // Range and reserved-opcode errors
    send(3'b001, 3'd3, 3'd5, 3'd0, 4'd2, 10'h010);
    check("rng_eimm", 32'(bus.err_imm), 32'd1);
    check("rng_eop", 32'(bus.err_op), 32'd0);
`ifdef IMM_SAT_EN
    check("sat_we", 32'(bus.mem_we), 32'd1);
    check("sat_wd", 32'(bus.mem_wdata), 32'h7559);
    check("sat_cnt", 32'(bus.err_count), 32'd0);
    exp_addr = exp_addr + 8'd1;
    exp_cnt  = 8'd1;
`else
    check("rng_we", 32'(bus.mem_we), 32'd0);
    check("rng_cnt", 32'(bus.err_count), 32'd1);
    check("rng_addr", 32'(bus.mem_addr), 32'(exp_addr));
    check("rng_rdy", 32'(bus.in_ready), 32'd1);
    exp_cnt = 8'd2;
`endif
    tick();
    check("rng_pulse_end", 32'(bus.err_imm), 32'd0);
    send(3'b110, 3'd1, 3'd1, 3'd1, 4'd1, 10'h000);
    check("op_eop", 32'(bus.err_op), 32'd1);
    check("op_eimm", 32'(bus.err_imm), 32'd0);
    check("op_we", 32'(bus.mem_we), 32'd0);
    check("op_cnt", 32'(bus.err_count), 32'(exp_cnt));
    check("op_addr", 32'(bus.mem_addr), 32'(exp_addr));
    tick();
    check("op_pulse_end", 32'(bus.err_op), 32'd0);

    // start ignored in ACCEPT
    do_start(8'h80);
    check("start_ign_addr", 32'(bus.mem_addr), 32'(exp_addr));

    // Stall: R-type held for three busy cycles
    bus.mem_busy = 1'b1;
    send(3'b000, 3'd2, 3'd4, 3'd6, 4'hA, 10'h000);
    for (int i = 0; i < 3; i++) begin
      check("stall_we", 32'(bus.mem_we), 32'd1);
      check("stall_addr", 32'(bus.mem_addr), 32'(exp_addr));
      check("stall_wd", 32'(bus.mem_wdata), 32'hAD10);
      check("stall_rdy", 32'(bus.in_ready), 32'd0);
      if (i == 2) bus.mem_busy = 1'b0;
      tick();
    end
    exp_addr = exp_addr + 8'd1;
    check("stall_release_we", 32'(bus.mem_we), 32'd0);
    check("stall_release_addr", 32'(bus.mem_addr), 32'(exp_addr));
    check("stall_release_rdy", 32'(bus.in_ready), 32'd1);

    // Reset during a stalled write
    bus.mem_busy = 1'b1;
    send(3'b011, 3'd0, 3'd1, 3'd2, 4'd0, 10'h005);
    check("pre_rst_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.mem_busy = 1'b0;
    check_all_zero("midrst");
    tick();
    check("midrst_idle_we", 32'(bus.mem_we), 32'd0);

    // End of session at LAST_ADDR
    do_start(8'd254);
    check("eos_addr0", 32'(bus.mem_addr), 32'd254);
    send(3'b001, 3'd3, 3'd5, 3'd0, 4'd2, 10'h3FD);
    check("eos_wd0", 32'(bus.mem_wdata), 32'hD559);
    tick();
    check("eos_addr1", 32'(bus.mem_addr), 32'd255);
    check("eos_done_early", 32'(bus.done), 32'd0);
    send(3'b101, 3'd7, 3'd0, 3'd0, 4'd0, 10'h2A5);
    check("eos_wd1", 32'(bus.mem_wdata), 32'hA97D);
    check("eos_addr_last", 32'(bus.mem_addr), 32'd255);
    tick();
    check("eos_done", 32'(bus.done), 32'd1);
    check("eos_rdy", 32'(bus.in_ready), 32'd0);
    check("eos_we", 32'(bus.mem_we), 32'd0);
    set_fields(3'b001, 3'd1, 3'd1, 3'd0, 4'd1, 10'h001);
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("eos_ign_we", 32'(bus.mem_we), 32'd0);
    check("eos_ign_done", 32'(bus.done), 32'd1);
    check("eos_ign_cnt", 32'(bus.err_count), 32'd0);

    // Restart from DONE at base 0
    do_start(8'd0);
    check("rs_done", 32'(bus.done), 32'd0);
    check("rs_rdy", 32'(bus.in_ready), 32'd1);
    check("rs_addr", 32'(bus.mem_addr), 32'd0);
    send(3'b011, 3'd0, 3'd1, 3'd2, 4'd0, 10'h005);
    check("rs_we", 32'(bus.mem_we), 32'd1);
    check("rs_wd", 32'(bus.mem_wdata), 32'h046B);
    check("rs_waddr", 32'(bus.mem_addr), 32'd0);
    tick();
    check("rs_next_addr", 32'(bus.mem_addr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
